// File: rtl/imem_pkg.sv
// Shared types and sizing helpers for the loadable instruction-memory bank.
// No logic of its own; widths and state encoding used by the bank and its controller.
// Not applicable (package only).
package imem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    // Bank operating state: one-shot preload, normal operation, streamed reload.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Source of the word written into any enabled entry this cycle.
    typedef enum logic [1:0] {
        SRC_INIT = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_LOAD = 2'd2
    } src_t;

    // Address width for a given depth (at least one bit).
    function automatic int addr_w(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// Mode controller: BOOT/RUN/LOAD sequencing, reload pointer and per-entry write enables.
// Write enables are combinational from current state and inputs; LOAD_READY/LOAD_DONE are registered.
// Reload stalls indefinitely while LOAD_VALID is low; READY drops on the edge of the last handshake.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter bit RESET_PRELOAD = 1'b1,
    localparam int AW           = addr_w(DEPTH)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             i_write_enable,
    input  logic [AW-1:0]    i_write_select,
    input  logic             i_load_start,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    output logic             o_load_done,
    output logic             o_busy,
    output src_t             o_src,
    output logic [DEPTH-1:0] o_entry_we
);

    localparam state_t        RST_STATE = RESET_PRELOAD ? ST_BOOT : ST_RUN;
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic          r_load_ready;
    logic          r_load_done;
    logic          w_handshake;
    logic          w_last;

    assign w_handshake = (r_state == ST_LOAD) && r_load_ready && i_load_valid;
    assign w_last      = w_handshake && (r_ptr == LAST_PTR);

    // State register; preload builds come out of reset in BOOT.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: BOOT lasts one cycle, LOAD ends on the final word's handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  if (i_load_start) w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_last) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Reload pointer plus registered READY/DONE; pointer holds at the last entry, never wraps.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_ptr        <= '0;
            r_load_ready <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_load_ready <= (w_state_nxt == ST_LOAD);
            r_load_done  <= w_last;
            if ((r_state == ST_RUN) && i_load_start) begin
                r_ptr <= '0;
            end else if (w_handshake && !w_last) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Outputs: which entries are written this cycle and from which source.
    always_comb begin
        o_busy     = (r_state != ST_RUN);
        o_src      = SRC_CPU;
        o_entry_we = '0;
        case (r_state)
            ST_BOOT: begin
                o_src      = SRC_INIT;
                o_entry_we = '1;
            end
            ST_RUN: begin
                if (i_write_enable) o_entry_we[i_write_select] = 1'b1;
            end
            ST_LOAD: begin
                o_src = SRC_LOAD;
                if (w_handshake) o_entry_we[r_ptr] = 1'b1;
            end
            default: o_entry_we = '0;
        endcase
    end

    assign o_load_ready = r_load_ready;
    assign o_load_done  = r_load_done;

endmodule

// File: rtl/imem_bank_loadable.sv
// Instruction-memory bank with one-shot preload, single-word writes and streamed bulk reload.
// Reads are combinational with no write bypass; a write at edge N is visible after edge N.
// Reload uses LOAD_VALID/LOAD_READY; BUSY tells the CPU to stall fetch during BOOT and LOAD.
module imem_bank_loadable
    import imem_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int DEPTH         = DEF_DEPTH,
    parameter bit RESET_PRELOAD = 1'b1,
    localparam int AW           = addr_w(DEPTH)
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic [DEPTH*DATA_W-1:0] INIT_IMAGE,
    input  logic                    WRITE_ENABLE,
    input  logic [AW-1:0]           WRITE_SELECT,
    input  logic [DATA_W-1:0]       IMEM_INPUT,
    input  logic [AW-1:0]           READ_SELECT,
    output logic [DATA_W-1:0]       IMEM_OUTPUT,
    input  logic [AW-1:0]           DBG_SELECT,
    output logic [DATA_W-1:0]       DBG_OUTPUT,
    input  logic                    LOAD_START,
    input  logic                    LOAD_VALID,
    input  logic [DATA_W-1:0]       LOAD_DATA,
    output logic                    LOAD_READY,
    output logic                    LOAD_DONE,
    output logic                    BUSY
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    src_t              w_src;
    logic [DEPTH-1:0]  w_entry_we;
    logic [DATA_W-1:0] w_wdat;

    imem_load_ctrl #(
        .DEPTH         (DEPTH),
        .RESET_PRELOAD (RESET_PRELOAD)
    ) u_ctrl (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .i_write_enable (WRITE_ENABLE),
        .i_write_select (WRITE_SELECT),
        .i_load_start   (LOAD_START),
        .i_load_valid   (LOAD_VALID),
        .o_load_ready   (LOAD_READY),
        .o_load_done    (LOAD_DONE),
        .o_busy         (BUSY),
        .o_src          (w_src),
        .o_entry_we     (w_entry_we)
    );

    // Shared write data for single-entry writes: reload stream or CPU port.
    always_comb begin
        w_wdat = (w_src == SRC_LOAD) ? LOAD_DATA : IMEM_INPUT;
    end

    // Storage: every entry cleared on reset; enabled entries take the preload word or shared data.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_entry_we[i]) begin
                    r_mem[i] <= (w_src == SRC_INIT) ? INIT_IMAGE[i*DATA_W +: DATA_W] : w_wdat;
                end
            end
        end
    end

    assign IMEM_OUTPUT = r_mem[READ_SELECT];
    assign DBG_OUTPUT  = r_mem[DBG_SELECT];

endmodule

// File: tb/tb_imem_bank_loadable.sv
// Directed bench for the loadable instruction-memory bank with a behavioural reference model.
// Inputs change 2 time units after the rising edge; the model updates on the edge, compare on falling edge.
// A second instance built without preload is watched for staying idle and zero.
module tb_imem_bank_loadable;

    localparam int DW = 16;
    localparam int DP = 16;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic [DP*DW-1:0] init_img;
    logic          we;
    logic [3:0]    ws;
    logic [15:0]   wd;
    logic [3:0]    rs;
    logic [3:0]    ds;
    logic          ls;
    logic          lv;
    logic [15:0]   ld;
    logic [15:0]   imem_out, dbg_out;
    logic          l_rdy, l_done, busy;
    logic [15:0]   np_imem, np_dbg;
    logic          np_rdy, np_done, np_busy;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    always #5 CLOCK = ~CLOCK;

    imem_bank_loadable #(.DATA_W(DW), .DEPTH(DP), .RESET_PRELOAD(1'b1)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .INIT_IMAGE(init_img),
        .WRITE_ENABLE(we), .WRITE_SELECT(ws), .IMEM_INPUT(wd),
        .READ_SELECT(rs), .IMEM_OUTPUT(imem_out),
        .DBG_SELECT(ds), .DBG_OUTPUT(dbg_out),
        .LOAD_START(ls), .LOAD_VALID(lv), .LOAD_DATA(ld),
        .LOAD_READY(l_rdy), .LOAD_DONE(l_done), .BUSY(busy)
    );

    imem_bank_loadable #(.DATA_W(DW), .DEPTH(DP), .RESET_PRELOAD(1'b0)) dut_np (
        .CLOCK(CLOCK), .RESET(RESET), .INIT_IMAGE(init_img),
        .WRITE_ENABLE(1'b0), .WRITE_SELECT(4'd0), .IMEM_INPUT(16'h0),
        .READ_SELECT(rs), .IMEM_OUTPUT(np_imem),
        .DBG_SELECT(ds), .DBG_OUTPUT(np_dbg),
        .LOAD_START(1'b0), .LOAD_VALID(1'b0), .LOAD_DATA(16'h0),
        .LOAD_READY(np_rdy), .LOAD_DONE(np_done), .BUSY(np_busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #2;
    endtask

    // Reference model: memory contents, whether the bank is booting, loading, and words received.
    logic [15:0] exp_mem [DP];
    bit          m_boot, m_load, m_done;
    int          m_words;

    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DP; i++) exp_mem[i] = 16'h0;
            m_boot  = 1'b1;
            m_load  = 1'b0;
            m_done  = 1'b0;
            m_words = 0;
        end else begin
            m_done = 1'b0;
            if (m_boot) begin
                for (int i = 0; i < DP; i++) exp_mem[i] = init_img[i*DW +: DW];
                m_boot = 1'b0;
            end else if (m_load) begin
                if (lv) begin
                    exp_mem[m_words] = ld;
                    m_words++;
                    if (m_words == DP) begin
                        m_load = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else begin
                if (we) exp_mem[ws] = wd;
                if (ls) begin
                    m_load  = 1'b1;
                    m_words = 0;
                end
            end
        end
    end

    // Every falling edge: both instances against the model.
    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("fetch", imem_out, exp_mem[rs]);
            chk("debug", dbg_out, exp_mem[ds]);
            chk("busy", 16'(busy), 16'(m_boot | m_load));
            chk("ready", 16'(l_rdy), 16'(m_load));
            chk("done", 16'(l_done), 16'(m_done));
            chk("np_busy", 16'(np_busy), 16'h0);
            chk("np_fetch", np_imem, 16'h0);
            chk("np_debug", np_dbg, 16'h0);
            chk("np_ready", 16'(np_rdy | np_done), 16'h0);
            if (l_done) done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c;
        for (int i = 0; i < DP; i++) init_img[i*DW +: DW] = 16'(16'hA000 + i);
        we = 0; ws = 0; wd = 0; rs = 0; ds = 0; ls = 0; lv = 0; ld = 0;

        // Reset state
        repeat (2) step();
        chk_en = 1'b1;
        #1;
        chk("rst_busy", 16'(busy), 16'h1);
        chk("rst_fetch", imem_out, 16'h0);
        chk("rst_ready", 16'(l_rdy), 16'h0);
        chk("np_rst_busy", 16'(np_busy), 16'h0);

        // Preload: BUSY for exactly one cycle
        RESET = 1'b1;
        #1 chk("boot_busy", 16'(busy), 16'h1);
        step();
        chk("run_busy", 16'(busy), 16'h0);
        rs = 5; ds = 15;
        #1;
        chk("preload_5", imem_out, 16'hA005);
        chk("preload_15", dbg_out, 16'hA00F);

        // Random write, not visible before the edge
        we = 1; ws = 3; wd = 16'h1234; rs = 3; ds = 4;
        #1 chk("wr_before", imem_out, 16'hA003);
        step();
        we = 0;
        #1;
        chk("wr_after", imem_out, 16'h1234);
        chk("wr_neighbor", dbg_out, 16'hA004);

        // Bulk reload with gaps; CPU writes and LOAD_START ignored meanwhile
        ls = 1;
        step();
        ls = 0;
        #1;
        chk("ld_ready", 16'(l_rdy), 16'h1);
        chk("ld_busy", 16'(busy), 16'h1);
        done_cnt = 0;
        k = 0; c = 0;
        while (k < DP && c < 100) begin
            lv = (c % 3 != 2);
            ld = 16'(16'hB000 + k);
            we = 1; ws = 2; wd = 16'hFFFF;
            ls = (c == 4);
            step();
            if (lv) k++;
            c++;
        end
        lv = 0; we = 0; ls = 0;
        #1;
        chk("ld_words", 16'(k), 16'd16);
        chk("ld_busy_after", 16'(busy), 16'h0);
        chk("ld_ready_after", 16'(l_rdy), 16'h0);
        step();
        step();
        chk("ld_done_once", 16'(done_cnt), 16'h1);
        ds = 7;
        #1 chk("ld_entry7", dbg_out, 16'hB007);
        ds = 2;
        #1 chk("ld_blocked_wr", dbg_out, 16'hB002);

        // Reset mid-load discards the partial reload
        ls = 1;
        step();
        ls = 0;
        for (int i = 0; i < 6; i++) begin
            lv = 1; ld = 16'(16'hD000 + i);
            step();
        end
        lv = 0; rs = 5; ds = 0;
        #1 chk("part_ld", dbg_out, 16'hD000);
        RESET = 1'b0;
        #1;
        chk("midrst_fetch", imem_out, 16'h0);
        chk("midrst_debug", dbg_out, 16'h0);
        chk("midrst_busy", 16'(busy), 16'h1);
        chk("midrst_ready", 16'(l_rdy), 16'h0);
        step();
        RESET = 1'b1;
        step();
        for (int i = 0; i < DP; i++) begin
            ds = 4'(i);
            #1 chk("reimage", dbg_out, 16'(16'hA000 + i));
        end
        chk("reimage_ready", 16'(l_rdy), 16'h0);

        // Write and LOAD_START together
        we = 1; ws = 9; wd = 16'h5555; ls = 1;
        step();
        we = 0; ls = 0; ds = 9;
        #1;
        chk("simul_wr", dbg_out, 16'h5555);
        chk("simul_ready", 16'(l_rdy), 16'h1);
        for (int i = 0; i < DP; i++) begin
            lv = 1; ld = 16'(16'hC000 + i);
            step();
            if (i == 8) chk("simul_hold", dbg_out, 16'h5555);
        end
        lv = 0;
        #1 chk("simul_overwrite", dbg_out, 16'hC009);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_bank_loadable.md
Name: imem_bank_loadable

Overview:
Parametrised instruction-memory bank for the i281 CPU, the generalised successor of the fixed 16x16 preloaded IMEM half.
- Preloads a constant program image on the first clock after reset.
- Supports single-word random writes in RUN.
- Adds a streamed bulk-reload mode with valid/ready handshake and a BUSY stall flag.
- Provides two independent asynchronous read ports: CPU fetch and visualizer debug.

Parameters:
DATA_W, 16, word width in bits
DEPTH, 16, number of words; power of two, 2..256; AW = clog2(DEPTH) (localparam)
RESET_PRELOAD, 1, 1 = load INIT_IMAGE on first clock after reset; 0 = skip BOOT, memory stays zero

Ports:
CLOCK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-low; clears all state
INIT_IMAGE  in  DEPTH*DATA_W  constant program image; word i = bits [i*DATA_W +: DATA_W]
WRITE_ENABLE  in  1  single-word write strobe (RUN only)
WRITE_SELECT  in  AW  write address
IMEM_INPUT  in  DATA_W  write data
READ_SELECT  in  AW  fetch read address
IMEM_OUTPUT  out  DATA_W  fetch read data (combinational)
DBG_SELECT  in  AW  debug read address
DBG_OUTPUT  out  DATA_W  debug read data (combinational)
LOAD_START  in  1  begin bulk reload (RUN only)
LOAD_VALID  in  1  LOAD_DATA valid
LOAD_DATA  in  DATA_W  reload word
LOAD_READY  out  1  bank accepting reload words
LOAD_DONE  out  1  one-cycle pulse after last word is stored
BUSY  out  1  high when state != RUN; CPU must stall fetch

Behaviour:
- Storage: DEPTH x DATA_W flops.
- Reads are purely combinational and have no write bypass. A write at edge N becomes visible on the outputs after edge N.
- States are BOOT, RUN and LOAD. The state register resets to BOOT when RESET_PRELOAD=1, otherwise to RUN.
- Reset (RESET=0, asynchronous):
  - all entries = 0; load pointer = 0; LOAD_READY = 0; LOAD_DONE = 0.
  - BUSY = 1 if RESET_PRELOAD=1, else 0.
  - IMEM_OUTPUT = DBG_OUTPUT = 0.
- BOOT:
  - On the first rising edge after RESET deasserts, every entry i <= INIT_IMAGE word i, and the state goes to RUN.
  - WRITE_ENABLE and LOAD_START are ignored in this cycle.
  - BUSY = 1 for exactly one cycle.
- RUN:
  - If WRITE_ENABLE=1: mem[WRITE_SELECT] <= IMEM_INPUT.
  - If LOAD_START=1: state -> LOAD, pointer <= 0.
  - If both are asserted in the same cycle, the write is performed and LOAD is also entered.
- LOAD:
  - LOAD_READY = 1 (registered; asserted the cycle after LOAD_START).
  - Each edge with LOAD_VALID & LOAD_READY: mem[pointer] <= LOAD_DATA, pointer++.
  - A handshake at pointer == DEPTH-1 moves the state to RUN, asserts LOAD_DONE for 1 cycle and drops LOAD_READY on that same edge.
  - No wrap-around: the pointer never exceeds DEPTH-1.
  - LOAD_VALID=0 stalls indefinitely, with no timeout.
  - WRITE_ENABLE and LOAD_START are ignored.
- LOAD_VALID outside LOAD is ignored. LOAD_START outside RUN is ignored.
- Reset mid-LOAD: asynchronous clear as above, then BOOT. A partial reload is discarded.
- BUSY is derived combinationally from the state register: high in BOOT and LOAD.

Decomposition:
- Package imem_pkg holds:
  - the state enum (BOOT, RUN, LOAD);
  - an address-width helper function (clog2);
  - default widths DATA_W=16, DEPTH=16.
- Sub-module imem_load_ctrl contains the FSM, load pointer, LOAD_READY/LOAD_DONE/BUSY logic and the per-entry write-enable vector.
- The top level holds the storage array, write-data selection (INIT_IMAGE / IMEM_INPUT / LOAD_DATA) and the two read muxes.

Test Plan:
1. Preload: INIT_IMAGE word i = 16'hA000+i, release RESET -> BUSY=1 for one cycle; then READ_SELECT=5 gives IMEM_OUTPUT=16'hA005 and DBG_SELECT=15 gives DBG_OUTPUT=16'hA00F.
2. Random write: in RUN, WRITE_ENABLE=1, WRITE_SELECT=3, IMEM_INPUT=16'h1234 -> READ_SELECT=3 shows 16'h1234 after the edge, not before; entry 4 stays 16'hA004.
3. Bulk reload with gaps: LOAD_START, then stream 16'hB000..16'hB00F with LOAD_VALID deasserted every third cycle -> LOAD_DONE pulses once after the 16th handshake; entry 7 = 16'hB007; BUSY low on the next cycle.
4. Writes blocked during LOAD: WRITE_ENABLE=1, WRITE_SELECT=2, IMEM_INPUT=16'hFFFF while in LOAD -> entry 2 ends as its reload value, not 16'hFFFF.
5. Reset mid-load: pull RESET low after 6 words -> outputs 0 immediately; after release, entries equal INIT_IMAGE and LOAD_READY=0.
6. Simultaneous events: WRITE_ENABLE (addr 9, 16'h5555) together with LOAD_START -> entry 9 = 16'h5555 until the reload overwrites it. Separately, RESET_PRELOAD=0 build -> BUSY=0 out of reset and all entries 0.
